transition_rate_monitor: RTL and testbench
==========================================

Name: transition_rate_monitor

Overview:
Sits directly downstream of the transition counter and consumes its free-running 64-bit transition count. It measures the count delta over fixed windows of WINDOW clock cycles and presents one rate sample per window on a valid/ready output. Each sample carries a high-threshold alarm flag. Windows that close while the previous sample is still unconsumed are dropped and counted in a saturating counter.

Parameters:
WINDOW, 1000, window length in clk cycles; legal range 2..2^32-1.
MISS_W, 8, width of the saturating dropped-sample counter.

Ports:
clk  input  1  system clock; all logic on the rising edge.
reset  input  1  asynchronous, active-high reset.
count  input  64  transition count from the upstream counter; monotonic except when the counter itself is reset.
enable  input  1  1 = measure; 0 = idle, with any partial window discarded.
hi_thresh  input  64  alarm threshold, sampled at window close.
rate  output  64  transitions counted in the last closed window.
rate_valid  output  1  rate and over_thresh hold a sample.
rate_ready  input  1  consumer accepts the sample.
over_thresh  output  1  rate > hi_thresh (strictly greater), registered with rate.
window_tick  output  1  one-cycle pulse on the cycle after each window close, including dropped closes.
missed  output  MISS_W  saturating count of dropped samples.

Behaviour:
- Reset is asynchronous and active-high. Reset values:
  - state = IDLE; win_cnt = 0; base = 0.
  - rate = 0; rate_valid = 0; over_thresh = 0; window_tick = 0; missed = 0.
- Reset mid-window discards everything. A pending sample is lost, and it does not count as missed.
- FSM has two states, IDLE and RUN:
  - IDLE, enable = 1: go to RUN; base <= count; win_cnt <= 0.
  - IDLE, enable = 0: stay in IDLE.
  - RUN, enable = 0: go to IDLE. The partial window is discarded. rate_valid, rate and missed are unaffected.
  - RUN, enable = 1, win_cnt < WINDOW-1: win_cnt <= win_cnt + 1.
  - RUN, enable = 1, win_cnt == WINDOW-1: this is a window close. delta is computed, base <= count, win_cnt <= 0, and the state stays RUN.
- Window timing: exactly WINDOW RUN edges from the entry (or previous close) edge to the close edge. Windows are back-to-back with no gap cycles.
- Delta arithmetic:
  - delta = count - base, 64-bit, when count >= base.
  - If count < base (the upstream counter was reset mid-window), delta = count. No error is flagged.
- Close latency: rate, over_thresh, rate_valid and window_tick update on the close edge and are visible in the following cycle.
- Output handshake:
  - A transfer occurs on an edge where rate_valid = 1 and rate_ready = 1.
  - rate and over_thresh are stable while rate_valid = 1 and no transfer has occurred.
  - Transfer edge, no close: rate_valid <= 0.
  - Close edge with rate_valid = 0: the new sample is loaded; rate_valid <= 1.
  - Close edge with a transfer on the same edge: the new sample is loaded; rate_valid stays 1; missed is unchanged.
  - Close edge with rate_valid = 1 and rate_ready = 0: the new sample is dropped and the old sample is held. missed <= missed + 1, saturating at 2^MISS_W - 1.
- rate_ready while rate_valid = 0 is ignored.
- hi_thresh is read only on close edges; changes between closes have no effect.
- enable toggling does not clear a pending sample.

Test Plan:
- WINDOW=4, rate_ready=1. Enable at count=10; count steps +1 per cycle. At the 4th RUN edge count=14 -> rate=4 and rate_valid=1 for one cycle, window_tick pulses, missed=0. This repeats every 4 cycles with rate=4.
- WINDOW=4, hi_thresh=3, rate_ready=0. Two consecutive closes -> rate holds the first sample (4) with over_thresh=1; missed=1; window_tick pulses twice. Raising rate_ready for one cycle clears rate_valid.
- WINDOW=4. rate_ready=1 on the exact close edge while the previous sample is pending -> the new sample is loaded and rate_valid stays 1, missed=0.
- WINDOW=4. Enter RUN with base=100; count drops to 2 mid-window and reads 3 at close -> rate=3.
- WINDOW=8. enable dropped after 5 RUN cycles, then re-raised at count=50 -> the partial window is discarded and the next close reports count-50 exactly 8 edges after re-entry.
- MISS_W=2, rate_ready=0 across 5 closes -> missed saturates at 3. Asserting reset mid-window -> all outputs are 0 immediately without waiting for a clk edge; state=IDLE.

Source files
------------

// File: rtl/transition_rate_monitor.sv
// transition_rate_monitor: windowed transition-rate sampler with valid/ready output, threshold alarm and dropped-sample counter
module transition_rate_monitor #(
  parameter int unsigned WINDOW = 1000,
  parameter int unsigned MISS_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [63:0]       count,
  input  logic              enable,
  input  logic [63:0]       hi_thresh,
  output logic [63:0]       rate,
  output logic              rate_valid,
  input  logic              rate_ready,
  output logic              over_thresh,
  output logic              window_tick,
  output logic [MISS_W-1:0] missed
);
  typedef enum logic {IDLE, RUN} state_t;
  localparam logic [31:0] LAST = WINDOW - 32'd1;
  state_t state, state_d;
  logic [31:0] win_cnt;
  logic [63:0] base, delta;
  logic close, load, drop;
  // state register
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_d;
  // enable alone decides whether we measure; dropping it abandons the window
  always_comb state_d = enable ? RUN : IDLE;
  // close decode, delta (falls back to raw count when upstream restarted) and handshake outcome
  always_comb begin
    close = state == RUN && enable && win_cnt == LAST;
    delta = count >= base ? count - base : count;
    load  = close && (!rate_valid || rate_ready);
    drop  = close && rate_valid && !rate_ready;
  end
  // window position and the count captured at window start
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      win_cnt <= '0;
      base    <= '0;
    end else begin
      win_cnt <= state == RUN && enable && !close ? win_cnt + 32'd1 : '0;
      base    <= enable && (state == IDLE || close) ? count : base;
    end
  // output sample register, tick pulse and saturating drop counter
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      rate        <= '0;
      rate_valid  <= 1'b0;
      over_thresh <= 1'b0;
      window_tick <= 1'b0;
      missed      <= '0;
    end else begin
      window_tick <= close;
      rate_valid  <= load || (rate_valid && !rate_ready);
      rate        <= load ? delta : rate;
      over_thresh <= load ? delta > hi_thresh : over_thresh;
      missed      <= drop && !(&missed) ? missed + MISS_W'(1) : missed;
    end
endmodule

// File: tb/tb_transition_rate_monitor.sv
// tb_transition_rate_monitor: scoreboard bench for transition_rate_monitor
module tb_transition_rate_monitor;
  logic clk = 1'b0, reset = 1'b0;
  logic [63:0] count_a, hi_a, rate_a, count_b, hi_b, rate_b;
  logic en_a, ready_a, valid_a, over_a, tick_a;
  logic en_b, ready_b, valid_b, over_b, tick_b;
  logic [1:0] missed_a;
  logic [7:0] missed_b;
  logic [64:0] q_a[$], q_b[$];
  logic [64:0] e_a, e_b;
  int checks = 0, errors = 0, ticks_a = 0, ticks_b = 0, t0;

  always #5 clk = ~clk;

  transition_rate_monitor #(.WINDOW(4), .MISS_W(2)) u_a (
    .clk(clk), .reset(reset), .count(count_a), .enable(en_a), .hi_thresh(hi_a),
    .rate(rate_a), .rate_valid(valid_a), .rate_ready(ready_a), .over_thresh(over_a),
    .window_tick(tick_a), .missed(missed_a));

  transition_rate_monitor #(.WINDOW(8), .MISS_W(8)) u_b (
    .clk(clk), .reset(reset), .count(count_b), .enable(en_b), .hi_thresh(hi_b),
    .rate(rate_b), .rate_valid(valid_b), .rate_ready(ready_b), .over_thresh(over_b),
    .window_tick(tick_b), .missed(missed_b));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk)
    if (!reset) begin
      if (tick_a) ticks_a++;
      if (valid_a && ready_a) begin
        if (q_a.size() == 0) chk("sb_a_extra_sample", 1, 0);
        else begin
          e_a = q_a.pop_front();
          chk("sb_a_rate", rate_a, e_a[63:0]);
          chk("sb_a_over", {63'd0, over_a}, {63'd0, e_a[64]});
        end
      end
    end

  always @(negedge clk)
    if (!reset) begin
      if (tick_b) ticks_b++;
      if (valid_b && ready_b) begin
        if (q_b.size() == 0) chk("sb_b_extra_sample", 1, 0);
        else begin
          e_b = q_b.pop_front();
          chk("sb_b_rate", rate_b, e_b[63:0]);
          chk("sb_b_over", {63'd0, over_b}, {63'd0, e_b[64]});
        end
      end
    end

  initial begin
    #50000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    {en_a, en_b, ready_a, ready_b} = '0;
    count_a = 0; count_b = 0; hi_a = 0; hi_b = 0;
    #2 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rate", rate_a, 0);
    chk("rst_valid", valid_a, 0);
    chk("rst_over", over_a, 0);
    chk("rst_tick", tick_a, 0);
    chk("rst_missed", missed_a, 0);
    @(negedge clk) reset = 1'b0;
    // steady windows, rate equal to threshold is not an alarm
    hi_a = 4; ready_a = 1; count_a = 10; en_a = 1; t0 = ticks_a;
    q_a.push_back({1'b0, 64'd4});
    q_a.push_back({1'b0, 64'd4});
    for (int k = 1; k <= 9; k++) begin tick(); count_a = count_a + 1; end
    en_a = 0;
    tick();
    chk("t1_valid_cleared", valid_a, 0);
    chk("t1_missed", missed_a, 0);
    chk("t1_ticks", ticks_a - t0, 2);
    // back-pressure: second close dropped
    hi_a = 3; ready_a = 0; count_a = 20; en_a = 1; t0 = ticks_a;
    for (int k = 1; k <= 9; k++) begin tick(); count_a = count_a + 1; end
    chk("t2_rate_held", rate_a, 4);
    chk("t2_over", over_a, 1);
    chk("t2_valid", valid_a, 1);
    chk("t2_missed", missed_a, 1);
    q_a.push_back({1'b1, 64'd4});
    ready_a = 1; en_a = 0;
    tick();
    ready_a = 0;
    chk("t2_valid_cleared", valid_a, 0);
    chk("t2_ticks", ticks_a - t0, 2);
    // transfer on the exact close edge
    hi_a = 100; count_a = 30; en_a = 1;
    q_a.push_back({1'b0, 64'd4});
    q_a.push_back({1'b0, 64'd6});
    for (int k = 1; k <= 8; k++) begin tick(); count_a = count_a + 1; end
    count_a = 40; ready_a = 1;
    tick();
    ready_a = 0;
    chk("t3_valid_kept", valid_a, 1);
    chk("t3_rate_new", rate_a, 6);
    chk("t3_missed_same", missed_a, 1);
    ready_a = 1; en_a = 0;
    tick();
    ready_a = 0;
    chk("t3_valid_cleared", valid_a, 0);
    // upstream counter reset mid-window
    hi_a = 2; ready_a = 1; count_a = 100; en_a = 1;
    q_a.push_back({1'b1, 64'd3});
    tick(); count_a = 101;
    tick(); count_a = 2;
    tick();
    tick(); count_a = 3;
    tick(); en_a = 0;
    tick();
    ready_a = 0;
    chk("t4_valid_cleared", valid_a, 0);
    // partial window discarded on enable drop (WINDOW=8)
    hi_b = 15; ready_b = 1; count_b = 0; en_b = 1;
    tick();
    for (int k = 1; k <= 5; k++) begin count_b = count_b + 1; tick(); end
    en_b = 0;
    tick();
    tick();
    count_b = 50; en_b = 1;
    tick();
    q_b.push_back({1'b1, 64'd16});
    for (int k = 1; k <= 8; k++) begin
      count_b = count_b + 2;
      tick();
      chk(k < 8 ? "t5_no_early_close" : "t5_close_on_8th", valid_b, k < 8 ? 0 : 1);
    end
    en_b = 0;
    tick();
    chk("t5_valid_cleared", valid_b, 0);
    chk("t5_ticks", ticks_b, 1);
    // missed saturation then asynchronous reset
    hi_a = 3; ready_a = 0; count_a = 60; en_a = 1; t0 = ticks_a;
    for (int k = 1; k <= 21; k++) begin tick(); count_a = count_a + 1; end
    chk("t6_ticks", ticks_a - t0, 4);
    chk("t6_tick_pulse", tick_a, 1);
    chk("t6_missed_sat", missed_a, 3);
    chk("t6_rate_held", rate_a, 4);
    chk("t6_valid", valid_a, 1);
    #1 reset = 1'b1;
    #1;
    chk("t6_async_rate", rate_a, 0);
    chk("t6_async_valid", valid_a, 0);
    chk("t6_async_over", over_a, 0);
    chk("t6_async_tick", tick_a, 0);
    chk("t6_async_missed", missed_a, 0);
    #1 reset = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      tick();
      count_a = count_a + 1;
      chk(k < 5 ? "t6_idle_reentry" : "t6_close_after_reset", valid_a, k < 5 ? 0 : 1);
    end
    chk("t6_rate_after_reset", rate_a, 4);
    chk("t6_missed_after_reset", missed_a, 0);
    q_a.push_back({1'b1, 64'd4});
    ready_a = 1; en_a = 0;
    tick();
    ready_a = 0;
    chk("t6_valid_cleared", valid_a, 0);
    chk("sb_a_drained", q_a.size(), 0);
    chk("sb_b_drained", q_b.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
